mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encoding, port ids
// and the access-counter width.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  // The port that is not p; used for round-robin alternation.
  function automatic port_t other_port(input port_t p);
    return (p == PORT_IF) ? PORT_D : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the fetch and data ports.
// MEM_ARB_RR_EN defined: round-robin on contention (port not in last_grant
// wins). Undefined: fixed priority, data port wins on contention and
// last_grant is ignored. A lone request always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  if_req,
  input  logic  d_req,
  input  port_t last_grant,
  output port_t grant,
  output logic  grant_valid
);

  // Pick the winner; grant is only meaningful while grant_valid is high.
  always_comb begin
    grant       = PORT_D;
    grant_valid = if_req | d_req;
    if (if_req && !d_req) begin
      grant = PORT_IF;
    end else if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      grant = other_port(last_grant);
`else
      grant = PORT_D;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority has no history; keep the port for a uniform interface.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single SRAM.
// Each access: IDLE samples requests and latches the winner, ACCESS holds the
// SRAM strobes for ACCESS_CYCLES cycles (legal 1..15), RESP pulses the
// winner's ack for one cycle. Latency sample->ack is ACCESS_CYCLES+1.
// Handshake: a requester raises req with stable addr/we/wdata and holds it
// until it sees its ack (a one-cycle pulse); req still high in IDLE after the
// ack is a new request. Inputs are not looked at again after the IDLE sample.
// Configuration macro: MEM_ARB_RR_EN selects round-robin arbitration
// (default undefined: fixed priority, data port wins on contention).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        sram_cs,
  output logic        sram_oe,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout,
  output state_t      dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, cap_if, cap_d;
  port_t            grant, last_grant, win_q;
  logic             grant_valid;
  logic [31:0]      addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic             we_q;

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // State and access counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and all SRAM/ack outputs decoded from the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    cap_if    = 1'b0;
    cap_d     = 1'b0;
    sram_cs   = 1'b0;
    sram_oe   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          load    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        sram_cs   = 1'b1;
        sram_we   = we_q;
        sram_oe   = ~we_q;
        sram_addr = addr_q;
        sram_din  = wdata_q;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          cap_if  = !we_q && (win_q == PORT_IF);
          cap_d   = !we_q && (win_q == PORT_D);
        end
      end
      RESP: begin
        if_ack  = (win_q == PORT_IF);
        d_ack   = (win_q == PORT_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's request so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= PORT_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (load) begin
      win_q   <= grant;
      addr_q  <= (grant == PORT_IF) ? if_addr : d_addr;
      we_q    <= (grant == PORT_D) && d_we;
      wdata_q <= (grant == PORT_D) ? d_wdata : '0;
    end
  end

  // Read data registers; each holds until its own port's next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (cap_if) if_rdata_q <= sram_dout;
      if (cap_d)  d_rdata_q  <= sram_dout;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember who won last so contention alternates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= PORT_D;
    else if (load) last_grant <= grant;
  end
`else
  assign last_grant = PORT_D;
`endif

  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset-abort and contention
// sequences, randomized traffic against a transaction-level model, and a
// second instance with ACCESS_CYCLES=1 for back-to-back throughput.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (ACCESS_CYCLES = 2) ----------------
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic        if_ack, d_ack, sram_cs, sram_oe, sram_we;
  logic [31:0] if_rdata, d_rdata, sram_addr, sram_din;
  logic [31:0] sram_dout = 0;
  state_t      dbg_state;

  mem_arbiter #(.ACCESS_CYCLES(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT (ACCESS_CYCLES = 1) ----------------
  logic        f1_req = 0, d1_req = 0, d1_we = 0;
  logic [31:0] f1_addr = 0, d1_addr = 0, d1_wdata = 0;
  logic        f1_ack, d1_ack, sram1_cs, sram1_oe, sram1_we;
  logic [31:0] f1_rdata, d1_rdata, sram1_addr, sram1_din, sram1_dout;
  state_t      dbg1_state;

  assign sram1_dout = (sram1_cs && sram1_oe) ? (sram1_addr ^ 32'h5A5A5A5A) : 32'hFFFF0000;

  mem_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(f1_req), .if_addr(f1_addr), .if_ack(f1_ack), .if_rdata(f1_rdata),
    .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
    .d_ack(d1_ack), .d_rdata(d1_rdata),
    .sram_cs(sram1_cs), .sram_oe(sram1_oe), .sram_we(sram1_we),
    .sram_addr(sram1_addr), .sram_din(sram1_din), .sram_dout(sram1_dout),
    .dbg_state(dbg1_state)
  );

  // ---------------- scoreboard counters / check ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic        preload = 1'b1;
  logic [31:0] sram_mem [0:31];

  function automatic logic [4:0] idx(input logic [31:0] a);
    return {a[28], a[22], a[4:2]};
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) sram_mem[i] <= 32'h0;
      sram_mem[idx(32'h00400000)] <= 32'h2008000A;
      sram_mem[idx(32'h00400004)] <= 32'h12345678;
    end else if (sram_cs && sram_we) begin
      sram_mem[idx(sram_addr)] <= sram_din;
    end
  end

  // Read data only valid while selected for read; garbage otherwise.
  always @(negedge clk) begin
    if (sram_cs && sram_oe) sram_dout = sram_mem[idx(sram_addr)];
    else                    sram_dout = $urandom;
  end

  // ---------------- bus monitor ----------------
  int          cs_cyc = 0, we_cyc = 0;
  logic        mon_en = 0, cur_we = 0;
  logic [31:0] cur_addr = 0, cur_wdata = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_ack && d_ack) check("dual_ack", 1, 0);
      if (sram_cs) begin
        cs_cyc++;
        if (sram_we) we_cyc++;
        check("oe_is_not_we", sram_oe, !sram_we);
        if (mon_en) begin
          check("sram_addr_latched", sram_addr, cur_addr);
          check("sram_we_latched", sram_we, cur_we);
          if (cur_we) check("sram_din_latched", sram_din, cur_wdata);
        end
      end else begin
        check("idle_we", sram_we, 0);
        check("idle_oe", sram_oe, 0);
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_if = 0, ref_d = 0;
  port_t       ref_last = PORT_D;

  function automatic logic [31:0] rm(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0;
  endfunction

  function automatic port_t model_pick_both(input port_t last);
`ifdef MEM_ARB_RR_EN
    return (last == PORT_D) ? PORT_IF : PORT_D;
`else
    return PORT_D;
`endif
  endfunction

  task automatic apply_model(input port_t p, input logic we, input logic [31:0] a, input logic [31:0] wd);
    if (p == PORT_IF)  ref_if = rm(a);
    else if (we)       ref_mem[a] = wd;
    else               ref_d = rm(a);
    ref_last = p;
  endtask

  // ---------------- drivers ----------------
  task automatic run_txn(input port_t port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit glitch,
                         output int lat, output bit other_ack);
    bit done;
    @(negedge clk);
    cur_addr = addr; cur_we = (port == PORT_D) && we; cur_wdata = wdata; mon_en = 1;
    if (port == PORT_IF) begin
      if_req = 1; if_addr = addr;
    end else begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    lat = 0; other_ack = 0; done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (glitch && lat == 1) begin
        if_addr = ~addr; d_addr = ~addr;
      end
      if ((port == PORT_IF) ? if_ack : d_ack) done = 1;
      if ((port == PORT_IF) ? d_ack : if_ack) other_ack = 1;
    end
    if_req = 0; d_req = 0; mon_en = 0;
  endtask

  task automatic run_pair(input logic [31:0] ia, input logic dwe, input logic [31:0] da,
                          input logic [31:0] dw, output port_t first, output bit ok);
    bit got_if, got_d;
    int cyc;
    @(negedge clk);
    if_req = 1; if_addr = ia; d_req = 1; d_we = dwe; d_addr = da; d_wdata = dw;
    got_if = 0; got_d = 0; first = PORT_IF; cyc = 0;
    while (!(got_if && got_d) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if_ack && !got_if) begin got_if = 1; if_req = 0; if (!got_d) first = PORT_IF; end
      if (d_ack && !got_d)   begin got_d = 1;  d_req = 0;  if (!got_if) first = PORT_D; end
    end
    if_req = 0; d_req = 0;
    ok = got_if && got_d;
  endtask

  function automatic logic [31:0] pick_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 8) return 32'h10010000 + 32'(4 * k);
    return 32'h00400000 + 32'(4 * (k - 8));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    port_t       port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          glitch;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [8];

  // ---------------- main sequence ----------------
  initial begin
    int    lat, w0, c0, cyc, k, last_cyc, acks, cs1;
    bit    oth, ok;
    port_t got, w, first, sec;
    logic  rwe;
    logic [31:0] ia, da, dw;

    vecs[0] = '{PORT_IF, 1'b0, 32'h00400000, 32'h0,        1'b0, 32'h2008000A, 32'h0};
    vecs[1] = '{PORT_D,  1'b1, 32'h10010000, 32'hDEADBEEF, 1'b0, 32'h2008000A, 32'h0};
    vecs[2] = '{PORT_D,  1'b0, 32'h10010000, 32'h0,        1'b0, 32'h2008000A, 32'hDEADBEEF};
    vecs[3] = '{PORT_IF, 1'b0, 32'h00400004, 32'h0,        1'b1, 32'h12345678, 32'hDEADBEEF};
    vecs[4] = '{PORT_D,  1'b1, 32'h10010004, 32'hCAFEF00D, 1'b0, 32'h12345678, 32'hDEADBEEF};
    vecs[5] = '{PORT_D,  1'b0, 32'h10010004, 32'h0,        1'b0, 32'h12345678, 32'hCAFEF00D};
    vecs[6] = '{PORT_IF, 1'b0, 32'h10010000, 32'h0,        1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[7] = '{PORT_D,  1'b0, 32'h00400000, 32'h0,        1'b0, 32'hDEADBEEF, 32'h2008000A};
    ref_mem[32'h00400000] = 32'h2008000A;
    ref_mem[32'h00400004] = 32'h12345678;

    // Reset state
    @(negedge clk);
    preload = 0;
    @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_cs", sram_cs, 0);
    check("rst_oe", sram_oe, 0);
    check("rst_we", sram_we, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_din", sram_din, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_n1_rdata", f1_rdata, 0);
    rst_n = 1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      w0 = we_cyc; c0 = cs_cyc;
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].glitch, lat, oth);
      apply_model(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_latency", i), lat, N + 1);
      check($sformatf("vec%0d_other_ack", i), oth, 0);
      check($sformatf("vec%0d_if_rdata", i), if_rdata, vecs[i].exp_if);
      check($sformatf("vec%0d_d_rdata", i), d_rdata, vecs[i].exp_d);
      check($sformatf("vec%0d_we_cycles", i), we_cyc - w0,
            (vecs[i].port == PORT_D && vecs[i].we) ? N : 0);
      check($sformatf("vec%0d_cs_cycles", i), cs_cyc - c0, N);
    end

    // Reset pulsed in the second ACCESS cycle aborts the fetch
    @(negedge clk);
    if_req = 1; if_addr = 32'h00400000;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_state", dbg_state, ACCESS);
    check("abort_pre_cs", sram_cs, 1);
    rst_n = 0;
    #1;
    check("abort_cs_drop", sram_cs, 0);
    check("abort_state", dbg_state, IDLE);
    check("abort_if_ack", if_ack, 0);
    check("abort_if_rdata", if_rdata, 0);
    check("abort_d_rdata", d_rdata, 0);
    if_req = 0;
    @(negedge clk);
    check("abort_hold_ack", if_ack | d_ack, 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_ack", if_ack | d_ack, 0);
      check("abort_idle", dbg_state, IDLE);
    end
    ref_if = 0; ref_d = 0; ref_last = PORT_D;

    // Contention: both held for 4 grants (first grant also proves recovery)
    @(negedge clk);
    ia = 32'h00400004; da = 32'h10010000;
    if_req = 1; if_addr = ia; d_req = 1; d_we = 0; d_addr = da;
    k = 0; cyc = 0; last_cyc = 0;
    while (k < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (if_ack || d_ack) begin
        got = if_ack ? PORT_IF : PORT_D;
        w = model_pick_both(ref_last);
        check($sformatf("grant%0d_port", k), got, w);
        check($sformatf("grant%0d_gap", k), cyc - last_cyc, (k == 0) ? N + 1 : N + 2);
        apply_model(w, 1'b0, (w == PORT_IF) ? ia : da, 32'h0);
        if (w == PORT_IF) check($sformatf("grant%0d_if_rdata", k), if_rdata, ref_if);
        else              check($sformatf("grant%0d_d_rdata", k), d_rdata, ref_d);
        last_cyc = cyc;
        k++;
      end
    end
    if_req = 0; d_req = 0;
    if (k < 4) check("contention_timeout", k, 4);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      k = $urandom_range(0, 3);
      if (k < 3) begin
        got = (k == 0) ? PORT_IF : PORT_D;
        rwe = (got == PORT_D) ? 1'($urandom_range(0, 1)) : 1'b0;
        ia = pick_addr(); dw = $urandom;
        w0 = we_cyc; c0 = cs_cyc;
        run_txn(got, rwe, ia, dw, 1'($urandom_range(0, 1)), lat, oth);
        apply_model(got, rwe, ia, dw);
        check($sformatf("rnd%0d_latency", it), lat, N + 1);
        check($sformatf("rnd%0d_other_ack", it), oth, 0);
        check($sformatf("rnd%0d_if_rdata", it), if_rdata, ref_if);
        check($sformatf("rnd%0d_d_rdata", it), d_rdata, ref_d);
        check($sformatf("rnd%0d_we_cycles", it), we_cyc - w0, rwe ? N : 0);
        check($sformatf("rnd%0d_cs_cycles", it), cs_cyc - c0, N);
      end else begin
        ia = pick_addr(); da = pick_addr(); dw = $urandom;
        rwe = 1'($urandom_range(0, 1));
        w = model_pick_both(ref_last);
        run_pair(ia, rwe, da, dw, first, ok);
        check($sformatf("pair%0d_done", it), ok, 1);
        check($sformatf("pair%0d_winner", it), first, w);
        sec = (w == PORT_IF) ? PORT_D : PORT_IF;
        apply_model(w, (w == PORT_D) && rwe, (w == PORT_IF) ? ia : da, dw);
        apply_model(sec, (sec == PORT_D) && rwe, (sec == PORT_IF) ? ia : da, dw);
        check($sformatf("pair%0d_if_rdata", it), if_rdata, ref_if);
        check($sformatf("pair%0d_d_rdata", it), d_rdata, ref_d);
      end
    end

    // ACCESS_CYCLES=1: back-to-back fetches, ack every 3 cycles
    @(negedge clk);
    f1_req = 1; f1_addr = 32'h00000100;
    acks = 0; cs1 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (sram1_cs) cs1++;
      check("n1_no_d_ack", d1_ack, 0);
      if (f1_ack) begin
        check($sformatf("n1_ack%0d_cycle", acks), c, 2 + 3 * acks);
        check($sformatf("n1_ack%0d_rdata", acks), f1_rdata, 32'h00000100 ^ 32'h5A5A5A5A);
        acks++;
      end
    end
    f1_req = 0;
    check("n1_ack_count", acks, 4);
    check("n1_cs_cycles", cs1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
